// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - front-panel run/pause/done controller for the 4-digit BCD stopwatch
// Optional lap-hold display freeze is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int D3_MAX = 9,
  parameter int D2_MAX = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_start,
  input  logic       btn_dir,
  input  logic       btn_clr,
  input  logic       btn_lap,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  output logic       go,
  output logic       back,
  output logic       clr,
  output logic [3:0] disp3,
  output logic [3:0] disp2,
  output logic [3:0] disp1,
  output logic [3:0] disp0,
  output logic       running,
  output logic       dir_down,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_n;

  logic prev_start, prev_dir, prev_clr;
  logic press_start, press_dir, press_clr;
  logic act_clr, act_start, act_dir;
  logic dir_down_n, clr_n;
  logic term;

  // Previous-value flops reset high so a button held through reset never fires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_start <= 1'b1;
      prev_dir   <= 1'b1;
      prev_clr   <= 1'b1;
    end else begin
      prev_start <= btn_start;
      prev_dir   <= btn_dir;
      prev_clr   <= btn_clr;
    end
  end

  assign press_start = btn_start & ~prev_start;
  assign press_dir   = btn_dir   & ~prev_dir;
  assign press_clr   = btn_clr   & ~prev_clr;

  // Only the highest-priority press in a cycle acts: clr > start > dir > lap.
  assign act_clr   = press_clr;
  assign act_start = press_start & ~press_clr;
  assign act_dir   = press_dir & ~press_clr & ~press_start;

  always_comb begin
    term = 1'b0;
    if (dir_down)
      term = ({d3, d2, d1, d0} == 16'h0000);
    else
      term = ({d3, d2, d1, d0} == {4'(D3_MAX), 4'(D2_MAX), 4'd9, 4'd9});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n    = state;
    dir_down_n = dir_down;
    clr_n      = 1'b0;
    if (act_clr) begin
      state_n    = IDLE;
      dir_down_n = 1'b0;
      clr_n      = 1'b1;
    end else begin
      case (state)
        IDLE, PAUSE: begin
          if (act_start)
            state_n = term ? DONE : RUN;
          else if (act_dir)
            dir_down_n = ~dir_down;
        end
        RUN: begin
          if (term)
            state_n = DONE;
          else if (act_start)
            state_n = PAUSE;
        end
        DONE: state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  // clr resets high so the counter is held clear through reset and the first edge after it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_down <= 1'b0;
      clr      <= 1'b1;
    end else begin
      dir_down <= dir_down_n;
      clr      <= clr_n;
    end
  end

  assign go      = (state == RUN) && !dir_down;
  assign back    = (state == RUN) && dir_down;
  assign running = (state == RUN);
  assign done    = (state == DONE);

`ifdef STOPWATCH_LAP_EN
  logic       prev_lap, press_lap, act_lap;
  logic       lap_hold, lap_hold_n, lap_cap;
  logic [3:0] lap3, lap2, lap1, lap0;

  assign press_lap = btn_lap & ~prev_lap;
  assign act_lap   = press_lap & ~press_clr & ~press_start & ~press_dir;

  always_comb begin
    lap_hold_n = lap_hold;
    lap_cap    = 1'b0;
    if (act_clr)
      lap_hold_n = 1'b0;
    else if (state_n == DONE && state != DONE)
      lap_hold_n = 1'b0;
    else if (act_lap && state != DONE) begin
      if (lap_hold)
        lap_hold_n = 1'b0;
      else if (state == RUN) begin
        lap_hold_n = 1'b1;
        lap_cap    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_lap <= 1'b1;
      lap_hold <= 1'b0;
      lap3     <= 4'd0;
      lap2     <= 4'd0;
      lap1     <= 4'd0;
      lap0     <= 4'd0;
    end else begin
      prev_lap <= btn_lap;
      lap_hold <= lap_hold_n;
      if (lap_cap) begin
        lap3 <= d3;
        lap2 <= d2;
        lap1 <= d1;
        lap0 <= d0;
      end
    end
  end

  assign disp3 = lap_hold ? lap3 : d3;
  assign disp2 = lap_hold ? lap2 : d2;
  assign disp1 = lap_hold ? lap1 : d1;
  assign disp0 = lap_hold ? lap0 : d0;
`else
  logic unused_btn_lap;
  assign unused_btn_lap = btn_lap;

  assign disp3 = d3;
  assign disp2 = d2;
  assign disp1 = d1;
  assign disp0 = d0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_start, btn_dir, btn_clr, btn_lap;
  logic [3:0] d3, d2, d1, d0;
  logic       go, back, clr, running, dir_down, done;
  logic [3:0] disp3, disp2, disp1, disp0;

  int compared = 0;
  int mismatched = 0;

  stopwatch_ctrl #(.D3_MAX(9), .D2_MAX(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_start(btn_start), .btn_dir(btn_dir), .btn_clr(btn_clr), .btn_lap(btn_lap),
    .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .go(go), .back(back), .clr(clr),
    .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0),
    .running(running), .dir_down(dir_down), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] e);
    d3 = a; d2 = b; d1 = c; d0 = e;
  endtask

  initial begin
    reset_n = 1'b0;
    btn_start = 0; btn_dir = 0; btn_clr = 0; btn_lap = 0;
    set_d(0, 0, 0, 0);
    #12;
    chk("rst_clr", clr, 1);
    chk("rst_run", running, 0);
    chk("rst_done", done, 0);
    chk("rst_dir", dir_down, 0);
    reset_n = 1'b1;
    #1;
    chk("rel_clr_before_edge", clr, 1);
    step();
    chk("rel_clr_drop", clr, 0);
    chk("rel_go", go, 0);
    chk("rel_back", back, 0);

    // Run up to terminal count
    btn_start = 1; step();
    chk("start_run", running, 1);
    chk("start_go", go, 1);
    chk("start_back", back, 0);
    btn_start = 0; step();
    set_d(9, 5, 9, 9);
    step();
    chk("term_done", done, 1);
    chk("term_go", go, 0);
    chk("disp_live", {disp3, disp2, disp1, disp0}, 16'h9599);
    btn_start = 1; step();
    chk("done_start_ign", done, 1);
    chk("done_start_go", go, 0);
    btn_start = 0; step();
    btn_dir = 1; step();
    chk("done_dir_ign", dir_down, 0);
    btn_dir = 0; step();
    btn_clr = 1; step();
    chk("clr_pulse", clr, 1);
    chk("clr_idle", done, 0);
    chk("clr_not_run", running, 0);
    btn_clr = 0; step();
    chk("clr_one_cycle", clr, 0);

    // Down from zero goes straight to DONE
    set_d(0, 0, 0, 0);
    btn_dir = 1; step();
    chk("idle_dir", dir_down, 1);
    btn_dir = 0; step();
    btn_start = 1; step();
    chk("dn_zero_done", done, 1);
    chk("dn_zero_back", back, 0);
    btn_start = 0; step();
    chk("dn_zero_back2", back, 0);
    btn_clr = 1; btn_start = 1; step();
    chk("prio_clr", clr, 1);
    chk("prio_idle_done", done, 0);
    chk("prio_idle_run", running, 0);
    chk("prio_dir_rst", dir_down, 0);
    btn_clr = 0; btn_start = 0; step();

    // Pause, reverse, resume
    set_d(0, 1, 2, 3);
    btn_start = 1; step();
    chk("run2_go", go, 1);
    btn_start = 0; step();
    btn_start = 1; step();
    chk("pause_run", running, 0);
    chk("pause_go", go, 0);
    btn_start = 0; step();
    btn_dir = 1; step();
    chk("pause_dir", dir_down, 1);
    btn_dir = 0; step();
    btn_start = 1; step();
    chk("resume_run", running, 1);
    chk("resume_back", back, 1);
    chk("resume_go", go, 0);
    btn_start = 0; step();
    btn_dir = 1; step();
    chk("run_dir_ign", dir_down, 1);
    btn_dir = 0; step();
    set_d(0, 0, 0, 0);
    step();
    chk("dn_term_done", done, 1);
    chk("dn_term_back", back, 0);
    btn_clr = 1; step();
    btn_clr = 0; step();

`ifdef STOPWATCH_LAP_EN
    set_d(0, 1, 2, 3);
    btn_start = 1; step();
    btn_start = 0; step();
    btn_lap = 1; step();
    set_d(0, 1, 3, 0);
    #1;
    chk("lap_hold_disp", {disp3, disp2, disp1, disp0}, 16'h0123);
    chk("lap_still_go", go, 1);
    btn_lap = 0; step();
    chk("lap_hold_disp2", {disp3, disp2, disp1, disp0}, 16'h0123);
    btn_lap = 1; step();
    chk("lap_release_disp", {disp3, disp2, disp1, disp0}, 16'h0130);
    btn_lap = 0; step();
    btn_clr = 1; step();
    btn_clr = 0; step();
`endif

    // Asynchronous reset mid-run
    set_d(0, 0, 4, 4);
    btn_start = 1; step();
    chk("pre_arst_run", running, 1);
    btn_start = 0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_run", running, 0);
    chk("arst_clr", clr, 1);

    // Button held through reset release must not fire
    btn_start = 1;
    #10;
    reset_n = 1'b1;
    step();
    step();
    chk("held_no_start", running, 0);
    btn_start = 0; step();
    chk("held_rel_idle", running, 0);
    btn_start = 1; step();
    chk("held_repress", running, 1);
    btn_start = 0; step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
